// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman frequency-sort sequencer: FSM encoding,
// default widths and the packed-bus entry slice helper.
package huff_pkg;

  localparam int unsigned DataWidthDef    = 16;
  localparam int unsigned TotalSymbolsDef = 10;
  localparam int unsigned AddrWidthDef    = 4;
  localparam int unsigned FillTimeoutDef  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFill,
    StSettle,
    StDrain,
    StErr
  } huff_state_e;

  // Bit offset of entry idx in a bus packed as entry i = bits [i*width +: width].
  function automatic int unsigned entry_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/huff_sort_drain.sv
// Drain engine: walks the sorted entries in ascending index order and presents them
// over a registered valid/ready port. HUFF_SORT_SKIP_ZERO_EN skips zero-frequency entries.
module huff_sort_drain
  import huff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DataWidthDef,
  parameter int unsigned TOTAL_SYMBOLS = TotalSymbolsDef,
  parameter int unsigned ADDR_WIDTH    = AddrWidthDef
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               launch_i,
  input  logic                               ready_i,
  input  logic [TOTAL_SYMBOLS*DATA_WIDTH-1:0] freq_bus_i,
  input  logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] sym_bus_i,
  output logic                               valid_o,
  output logic                               last_o,
  output logic                               any_nz_o,
  output logic                               last_fire_o,
  output logic [DATA_WIDTH-1:0]              freq_o,
  output logic [ADDR_WIDTH-1:0]              sym_o
);

  logic [DATA_WIDTH-1:0] freq_ent [TOTAL_SYMBOLS];
  logic [ADDR_WIDTH-1:0] sym_ent  [TOTAL_SYMBOLS];
`ifdef HUFF_SORT_SKIP_ZERO_EN
  logic [TOTAL_SYMBOLS-1:0] nz;
  logic [TOTAL_SYMBOLS-1:0] nz_from;
`endif

  for (genvar g = 0; g < TOTAL_SYMBOLS; g++) begin : g_ent
    assign freq_ent[g] = freq_bus_i[entry_lsb(g, DATA_WIDTH) +: DATA_WIDTH];
    assign sym_ent[g]  = sym_bus_i[entry_lsb(g, ADDR_WIDTH) +: ADDR_WIDTH];
`ifdef HUFF_SORT_SKIP_ZERO_EN
    assign nz[g] = |freq_ent[g];
`endif
  end

  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] freq_q;
  logic [ADDR_WIDTH-1:0] sym_q;
  logic                  valid_q, last_q, active_q;
  logic                  fire, scan, step, cand_zero, cand_last;
  logic [ADDR_WIDTH-1:0] cand;

  always_comb begin
    fire = valid_q && ready_i;
    // A zero entry leaves valid low; the next cycle advances one entry further.
    scan = active_q && !valid_q;
    step = launch_i || (fire && !last_q) || scan;
    cand = launch_i ? '0 : idx_q + 1'b1;
`ifdef HUFF_SORT_SKIP_ZERO_EN
    nz_from   = nz >> cand;
    cand_zero = !nz[cand];
    cand_last = !(|nz_from[TOTAL_SYMBOLS-1:1]);
`else
    cand_zero = 1'b0;
    cand_last = (cand == ADDR_WIDTH'(TOTAL_SYMBOLS - 1));
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q    <= '0;
      freq_q   <= '0;
      sym_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      active_q <= 1'b0;
    end else if (step) begin
      idx_q    <= cand;
      freq_q   <= freq_ent[cand];
      sym_q    <= sym_ent[cand];
      valid_q  <= !cand_zero;
      last_q   <= cand_last && !cand_zero;
      active_q <= 1'b1;
    end else if (fire) begin
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      active_q <= 1'b0;
    end
  end

  assign valid_o     = valid_q;
  assign last_o      = last_q;
  assign freq_o      = freq_q;
  assign sym_o       = sym_q;
  assign last_fire_o = fire && last_q;
`ifdef HUFF_SORT_SKIP_ZERO_EN
  assign any_nz_o = |nz;
`else
  assign any_nz_o = 1'b1;
`endif

endmodule

// File: rtl/huffman_sort_ctrl.sv
// Sequencer for the Huffman sort chain: clear, fill with timeout, settle, then drain
// sorted pairs. HUFF_SORT_SKIP_ZERO_EN enables skipping zero-frequency entries.
module huffman_sort_ctrl
  import huff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DataWidthDef,
  parameter int unsigned TOTAL_SYMBOLS = TotalSymbolsDef,
  parameter int unsigned ADDR_WIDTH    = AddrWidthDef,
  parameter int unsigned FILL_TIMEOUT  = FillTimeoutDef
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic                               sort_sload,
  output logic                               sort_ena,
  input  logic                               sort_done,
  input  logic [TOTAL_SYMBOLS*DATA_WIDTH-1:0] sort_b,
  input  logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] sort_ab,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_freq,
  output logic [ADDR_WIDTH-1:0]              out_sym,
  output logic                               out_last,
  output logic                               run_done,
  output logic                               err
);

  localparam int unsigned CntW = $clog2(FILL_TIMEOUT);

  huff_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            busy_q, sload_q, ena_q, run_done_q, err_q;
  logic            last_fire, any_nz;

  huff_sort_drain #(
    .DATA_WIDTH    (DATA_WIDTH),
    .TOTAL_SYMBOLS (TOTAL_SYMBOLS),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_drain (
    .clk_i       (clk),
    .rst_i       (rst),
    .launch_i    (state_q == StSettle && any_nz),
    .ready_i     (out_ready),
    .freq_bus_i  (sort_b),
    .sym_bus_i   (sort_ab),
    .valid_o     (out_valid),
    .last_o      (out_last),
    .any_nz_o    (any_nz),
    .last_fire_o (last_fire),
    .freq_o      (out_freq),
    .sym_o       (out_sym)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StClear;
      StClear:  state_d = StFill;
      StFill: begin
        if (sort_done) state_d = StSettle;
        else if (cnt_q == CntW'(FILL_TIMEOUT - 1)) state_d = StErr;
      end
      StSettle: state_d = any_nz ? StDrain : StIdle;
      StDrain:  if (last_fire) state_d = StIdle;
      StErr:    if (start) state_d = StClear;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      sload_q    <= 1'b0;
      ena_q      <= 1'b0;
      run_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= (state_q == StFill) ? cnt_q + 1'b1 : '0;
      busy_q     <= (state_d != StIdle);
      sload_q    <= (state_d == StClear);
      ena_q      <= (state_d == StClear) || (state_d == StFill);
      run_done_q <= (state_q == StDrain && last_fire) || (state_q == StSettle && !any_nz);
      if (state_d == StClear) err_q <= 1'b0;
      else if (state_d == StErr) err_q <= 1'b1;
    end
  end

  assign busy       = busy_q;
  assign sort_sload = sload_q;
  assign sort_ena   = ena_q;
  assign run_done   = run_done_q;
  assign err        = err_q;

endmodule
